vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Sole owner of the single-port pixel framebuffer RAM (HD x VD entries, PIX_W bits each).
- Shares the RAM between two requesters:
  - the scanout line prefetcher, which fetches one full display line into the line buffer ahead of display;
  - two pixel writers (host port 0, drawing engine port 1), arbitrated round-robin.
- Scanout has priority, with a bounded-starvation slot for writers.
- Sits between the timing generator (line_start and line_idx from the hcount/vcount logic), the line buffer and the framebuffer RAM.

Parameters:
- HD, 1280, pixels per line.
- VD, 1024, lines per frame.
- PIX_W, 2, pixel width in bits.
- ADDR_W, 21, framebuffer address width (must satisfy 2^ADDR_W >= HD*VD).
- COL_W, 11, column/line index width.
- MAX_BURST, 8, max consecutive scanout reads before one writer slot is forced (>=1).

Ports:
- clk  in  1  clock.
- arstn  in  1  reset, asynchronous, active-low.
- line_start  in  1  one-cycle pulse: begin fetching line line_idx.
- line_idx  in  COL_W  line to fetch; sampled when line_start=1.
- fetch_busy  out  1  prefetch in progress.
- fetch_done  out  1  one-cycle pulse, concurrent with the final lb_we.
- overrun  out  1  one-cycle pulse: line_start arrived while fetch_busy=1.
- lb_we  out  1  line buffer write enable.
- lb_addr  out  COL_W  line buffer column.
- lb_wdata  out  PIX_W  line buffer pixel.
- wr0_valid / wr1_valid  in  1  writer request.
- wr0_ready / wr1_ready  out  1  writer grant; a transfer occurs when valid&ready.
- wr0_addr / wr1_addr  in  ADDR_W  pixel address.
- wr0_data / wr1_data  in  PIX_W  pixel data.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  PIX_W  RAM write data.
- mem_rdata  in  PIX_W  RAM read data, valid 1 cycle after a read.

Behaviour:
- Reset: state IDLE. All of the following are 0: fetch_busy, fetch_done, overrun, lb_we, lb_addr, lb_wdata, wrN_ready, mem_en, mem_we, mem_addr, mem_wdata. Also rr pointer=0 (port 0 preferred first), burst_cnt=0, col=0.
- One RAM operation per cycle max.
- Outputs are driven combinationally from registered state and current requester inputs. lb_* are registered.
- FSM states:
  - IDLE: writers only.
  - FETCH: issue reads.
  - DRAIN: wait for last read data.
- IDLE -> FETCH:
  - Condition: line_start=1 and line_idx < VD.
  - Actions: base <= line_idx*HD, col <= 0, burst_cnt <= 0.
  - line_start with line_idx >= VD is ignored.
- FETCH cycle, read slot:
  - Condition: burst_cnt < MAX_BURST, or no writer valid.
  - Issue read: mem_en=1, mem_we=0, mem_addr=base+col.
  - col++; burst_cnt++ (saturating at MAX_BURST).
- FETCH cycle, writer slot:
  - Condition: burst_cnt == MAX_BURST and some writer valid.
  - Grant one writer; burst_cnt <= 0; col holds.
- FETCH -> DRAIN: after the read with col == HD-1 is issued.
- DRAIN -> IDLE: next cycle. Writers may be granted in DRAIN.
- Read return:
  - The cycle after each read: lb_we=1, lb_addr=column of that read, lb_wdata=mem_rdata.
  - fetch_done=1 with the col HD-1 write.
- fetch_busy=1 in FETCH and DRAIN.
- Fetch latency: HD + (writer slots taken) + 1 cycles from line_start to fetch_done.
- Writer grant:
  - Only one wrN_ready high per cycle; ready is never high when valid is low.
  - Both valid: grant the port != last granted; rr pointer updates only on a transfer.
  - Granted write: mem_en=1, mem_we=1, mem_addr=wrN_addr, mem_wdata=wrN_data.
- Write address out of range (wrN_addr >= HD*VD): ready asserted (transfer consumed), mem_en=0 that cycle. The slot still counts.
- line_start while fetch_busy=1:
  - overrun=1 for that cycle.
  - Current fetch aborted: no fetch_done, pending DRAIN return still written to lb.
  - If new line_idx < VD, restart FETCH on the new line next cycle; else go IDLE.
- line_start in the same cycle as a writer request in IDLE:
  - Writer is granted that cycle.
  - FETCH begins next cycle.
- arstn asserted mid-operation: immediate return to reset values. Any in-flight read data is discarded (no lb_we).
- Arithmetic: base+col computed at ADDR_W bits, no wrap possible given the parameter constraint.

Test Plan:
- Use HD=8, VD=4, MAX_BURST=2 for all scenarios unless stated otherwise.
- Basic fetch: line_start, line_idx=2, no writers -> mem_addr 16..23 on consecutive cycles; lb_we at cols 0..7 one cycle later; fetch_done on the 9th cycle after start; fetch_busy high 9 cycles.
- Starvation bound: wr0_valid held high during fetch of line 1 -> pattern R,R,W,R,R,W,R,R,W,R,R. fetch_done 12 cycles after start; all 8 lb writes correct.
- Round-robin in IDLE: both writers valid for 4 cycles with addrs 3/5 -> grants alternate wr0,wr1,wr0,wr1; RAM writes to 3,5,3,5.
- Out-of-range write: wr1_addr=32 -> wr1_ready=1, mem_en=0 that cycle.
- Overrun: line_start(line 0) then line_start(line 3) 4 cycles later -> overrun pulse; no fetch_done for line 0; reads 24..31 follow; single fetch_done.
- Reset mid-fetch: arstn low at col 5 -> all outputs 0 immediately; after release, no lb_we and FSM in IDLE.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Owns the single-port framebuffer RAM: scanout line prefetch has priority, and two pixel
// writers share the remaining slots round-robin. A writer slot is forced after MAX_BURST reads.
module vga_fb_arbiter #(
  parameter int HD        = 1280,
  parameter int VD        = 1024,
  parameter int PIX_W     = 2,
  parameter int ADDR_W    = 21,
  parameter int COL_W     = 11,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              line_start,
  input  logic [COL_W-1:0]  line_idx,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              overrun,
  output logic              lb_we,
  output logic [COL_W-1:0]  lb_addr,
  output logic [PIX_W-1:0]  lb_wdata,
  input  logic              wr0_valid,
  output logic              wr0_ready,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [PIX_W-1:0]  wr0_data,
  input  logic              wr1_valid,
  output logic              wr1_ready,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [PIX_W-1:0]  wr1_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int COL_W1  = COL_W + 1;
  localparam int ADDR_W1 = ADDR_W + 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(HD - 1);
  localparam logic [COL_W:0]     VD_LIM    = COL_W1'(VD);
  localparam logic [ADDR_W:0]    FB_LIM    = ADDR_W1'(HD * VD);
  localparam logic [ADDR_W-1:0]  HD_A      = ADDR_W'(HD);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               rr_q, rr_d;
  logic               lb_we_q, lb_we_d;
  logic [COL_W-1:0]   lb_addr_q, lb_addr_d;
  logic               lb_last_q, lb_last_d;

  logic              busy, line_ok, abort, any_valid;
  logic              rd_slot, wr_slot, gnt0, gnt1, gnt_any, in_range;
  logic [ADDR_W-1:0] sel_addr, rd_addr;
  logic [PIX_W-1:0]  sel_data;

  assign busy      = (state_q != ST_IDLE);
  assign line_ok   = ({1'b0, line_idx} < VD_LIM);
  assign abort     = line_start & busy;
  assign any_valid = wr0_valid | wr1_valid;

  // A read is skipped only when the burst budget is spent and a writer is actually waiting.
  assign rd_slot = (state_q == ST_FETCH) & ~abort & ((burst_q != BURST_MAX) | ~any_valid);
  assign wr_slot = arstn & ~rd_slot;

  // rr_q names the port preferred on a tie; a lone requester is always served.
  assign gnt1     = wr_slot & wr1_valid & (~wr0_valid | rr_q);
  assign gnt0     = wr_slot & wr0_valid & ~gnt1;
  assign gnt_any  = gnt0 | gnt1;
  assign sel_addr = gnt1 ? wr1_addr : wr0_addr;
  assign sel_data = gnt1 ? wr1_data : wr0_data;
  assign in_range = ({1'b0, sel_addr} < FB_LIM);
  assign rd_addr  = base_q + ADDR_W'(col_q);

  assign wr0_ready  = gnt0;
  assign wr1_ready  = gnt1;
  assign mem_we     = gnt_any & in_range;
  assign mem_en     = rd_slot | mem_we;
  assign mem_addr   = rd_slot ? rd_addr : (mem_we ? sel_addr : '0);
  assign mem_wdata  = mem_we ? sel_data : '0;

  assign fetch_busy = busy;
  assign overrun    = abort;
  assign lb_we      = lb_we_q;
  assign lb_addr    = lb_addr_q;
  assign lb_wdata   = lb_we_q ? mem_rdata : '0;
  // An aborted fetch still lands its last pixel but never reports completion.
  assign fetch_done = lb_we_q & lb_last_q & ~line_start;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    base_d    = base_q;
    col_d     = col_q;
    burst_d   = burst_q;
    rr_d      = rr_q;
    lb_we_d   = rd_slot;
    lb_addr_d = rd_slot ? col_q : '0;
    lb_last_d = rd_slot & (col_q == LAST_COL);

    if (gnt_any) rr_d = gnt0;

    case (state_q)
      ST_IDLE:  ;
      ST_FETCH: begin
        if (rd_slot) begin
          col_d   = col_q + 1'b1;
          burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
          if (col_q == LAST_COL) state_d = ST_DRAIN;
        end else begin
          burst_d = '0;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A new line request overrides whatever the current state was doing.
    if (line_start) begin
      if (line_ok) begin
        state_d = ST_FETCH;
        base_d  = ADDR_W'(line_idx) * HD_A;
        col_d   = '0;
        burst_d = '0;
      end else if (busy) begin
        state_d = ST_IDLE;
      end
    end
  end

  // NOTE: state uses non-blocking assignments and an async active-low reset; in-flight reads die here.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      col_q     <= '0;
      burst_q   <= '0;
      rr_q      <= 1'b0;
      lb_we_q   <= 1'b0;
      lb_addr_q <= '0;
      lb_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      col_q     <= col_d;
      burst_q   <= burst_d;
      rr_q      <= rr_d;
      lb_we_q   <= lb_we_d;
      lb_addr_q <= lb_addr_d;
      lb_last_q <= lb_last_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: a behavioural RAM plus a slot-level model of
// fetch/writer scheduling, driven by directed and randomized scenarios.
module tb_vga_fb_arbiter;

  localparam int HD     = 8;
  localparam int VD     = 4;
  localparam int PIX_W  = 2;
  localparam int ADDR_W = 6;
  localparam int COL_W  = 4;
  localparam int MB     = 2;
  localparam int FB     = HD * VD;
  localparam int RAM_N  = 1 << ADDR_W;
  localparam int OUT_W  = 8 + COL_W + ADDR_W + 2 * PIX_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arstn, line_start;
  logic [COL_W-1:0]  line_idx;
  logic              fetch_busy, fetch_done, overrun;
  logic              lb_we;
  logic [COL_W-1:0]  lb_addr;
  logic [PIX_W-1:0]  lb_wdata;
  logic              wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [ADDR_W-1:0] wr0_addr, wr1_addr;
  logic [PIX_W-1:0]  wr0_data, wr1_data;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata, mem_rdata;

  vga_fb_arbiter #(
    .HD(HD), .VD(VD), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .COL_W(COL_W), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .arstn(arstn),
    .line_start(line_start), .line_idx(line_idx),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .overrun(overrun),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int model_pref = 0;

  // mram is the expected RAM image; dut_ram is the physical RAM the DUT talks to.
  logic [PIX_W-1:0] mram    [RAM_N];
  logic [PIX_W-1:0] dut_ram [RAM_N];
  logic             ram_load;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < RAM_N; i++) dut_ram[i] <= mram[i];
    end else if (mem_en) begin
      if (mem_we) dut_ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= dut_ram[mem_addr];
    end
  end

  function automatic logic [OUT_W-1:0] all_outs();
    return {fetch_busy, fetch_done, overrun, lb_we, lb_addr, lb_wdata,
            wr0_ready, wr1_ready, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  function automatic int pick_addr(input int line, input bit allow_oor);
    int a;
    do a = $urandom_range(0, allow_oor ? FB + 7 : FB - 1);
    while (a >= line * HD && a < line * HD + HD);
    return a;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_quiet();
    line_start = 1'b0; line_idx = '0;
    wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    drive_quiet();
    wr0_valid = 1'b1; wr1_valid = 1'b1; wr0_addr = 6'd3; wr1_addr = 6'd5;
    ram_load = 1'b1;
    next_cycle();
    next_cycle();
    ram_load = 1'b0;
    #3;
    vec_cnt++;
    if (all_outs() !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h, want 0", all_outs());
    end
    next_cycle();
    arstn = 1'b1;
    drive_quiet();
    #3;
    vec_cnt++;
    if (all_outs() !== '0) begin
      err_cnt++;
      $display("FAIL reset_release_idle: got %h, want 0", all_outs());
    end
    model_pref = 0;
  endtask

  task automatic test_round_robin();
    logic [PIX_W-1:0] d0, d1, xd;
    int g, xa;
    for (int k = 0; k < 4; k++) begin
      d0 = PIX_W'($urandom); d1 = PIX_W'($urandom);
      next_cycle();
      wr0_valid = 1'b1; wr0_addr = 6'd3; wr0_data = d0;
      wr1_valid = 1'b1; wr1_addr = 6'd5; wr1_data = d1;
      #3;
      g  = k % 2;
      xa = g ? 5 : 3;
      xd = g ? d1 : d0;
      vec_cnt++;
      if ({wr0_ready, wr1_ready, mem_en, mem_we, mem_addr, mem_wdata} !==
          {g == 0, g == 1, 1'b1, 1'b1, ADDR_W'(xa), xd}) begin
        err_cnt++;
        $display("FAIL rr_grant[%0d]: got r0=%b r1=%b en=%b we=%b a=%0d d=%0d, want port %0d a=%0d d=%0d",
                 k, wr0_ready, wr1_ready, mem_en, mem_we, mem_addr, mem_wdata, g, xa, xd);
      end
      mram[xa] = xd;
    end
    model_pref = 0;
    next_cycle();
    drive_quiet();
    #3;
    vec_cnt++;
    if ({wr0_ready, wr1_ready, mem_en} !== 3'b000) begin
      err_cnt++;
      $display("FAIL rr_no_valid: got r0=%b r1=%b en=%b, want 000", wr0_ready, wr1_ready, mem_en);
    end
  endtask

  // Idle writer table: out-of-range on each port, top in-range address, and ties.
  task automatic test_out_of_range();
    bit v0s [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bit v1s [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int a0s [4] = '{0, 31, 63, 63};
    int a1s [4] = '{32, 0, 10, 10};
    logic [PIX_W-1:0] d0, d1, gd;
    int g, ga;
    bit x_en;
    for (int k = 0; k < 4; k++) begin
      d0 = PIX_W'($urandom); d1 = PIX_W'($urandom);
      next_cycle();
      wr0_valid = v0s[k]; wr0_addr = ADDR_W'(a0s[k]); wr0_data = d0;
      wr1_valid = v1s[k]; wr1_addr = ADDR_W'(a1s[k]); wr1_data = d1;
      #3;
      g = (v0s[k] && v1s[k]) ? model_pref : (v0s[k] ? 0 : 1);
      model_pref = 1 - g;
      ga = g ? a1s[k] : a0s[k];
      gd = g ? d1 : d0;
      x_en = (ga < FB);
      vec_cnt++;
      if ({wr0_ready, wr1_ready, mem_en, mem_we} !== {g == 0, g == 1, x_en, x_en}) begin
        err_cnt++;
        $display("FAIL oor_grant[%0d]: got r0=%b r1=%b en=%b we=%b, want port %0d en=%b",
                 k, wr0_ready, wr1_ready, mem_en, mem_we, g, x_en);
      end
      if (x_en) begin
        vec_cnt++;
        if ({mem_addr, mem_wdata} !== {ADDR_W'(ga), gd}) begin
          err_cnt++;
          $display("FAIL oor_write[%0d]: got a=%0d d=%0d, want a=%0d d=%0d", k, mem_addr, mem_wdata, ga, gd);
        end
        mram[ga] = gd;
      end
    end
    next_cycle();
    drive_quiet();
  endtask

  // mode 0: no writers, 1: wr0 held valid, 2: random writers incl. out-of-range addresses.
  task automatic run_fetch(input int line, input int mode, input int exp_lat);
    int reads, since, slots, c, done_cnt, done_at, base, g, ga, a0, a1, x_addr, x_col;
    bit drained, ended, post_ph, fetch_ph, drain_ph, wr_ok, v0, v1;
    bit x_en, x_we, x_r0, x_r1, x_lb, x_done, x_busy, pend_v;
    int pend_col;
    logic [PIX_W-1:0] d0, d1, gd, x_wd, x_dat, pend_dat;
    reads = 0; since = 0; slots = 0; c = 0; done_cnt = 0; done_at = -1;
    base = line * HD; drained = 0; ended = 0; pend_v = 0; pend_col = 0; pend_dat = '0;
    while (!ended && c < 4 * HD + 8) begin
      post_ph = drained;
      v0 = 0; v1 = 0; a0 = 0; a1 = 0;
      d0 = PIX_W'($urandom); d1 = PIX_W'($urandom);
      if (!post_ph) begin
        if (mode == 1) v0 = 1;
        if (mode == 2) begin
          v0 = ($urandom_range(0, 1) == 1);
          v1 = ($urandom_range(0, 1) == 1);
        end
        a0 = pick_addr(line, mode == 2);
        a1 = pick_addr(line, mode == 2);
      end
      next_cycle();
      line_start = (c == 0); line_idx = COL_W'(line);
      wr0_valid = v0; wr0_addr = ADDR_W'(a0); wr0_data = d0;
      wr1_valid = v1; wr1_addr = ADDR_W'(a1); wr1_data = d1;
      #3;

      x_lb = pend_v; x_col = pend_col; x_dat = pend_dat;
      x_done = pend_v && (pend_col == HD - 1);
      pend_v = 0;
      fetch_ph = (c >= 1) && (reads < HD);
      drain_ph = (c >= 1) && (reads == HD) && !drained;
      x_busy = fetch_ph || drain_ph;
      x_en = 0; x_we = 0; x_r0 = 0; x_r1 = 0; x_addr = 0; x_wd = '0;
      wr_ok = !fetch_ph;
      if (fetch_ph) begin
        if (since == MB && (v0 || v1)) begin
          wr_ok = 1; since = 0; slots++;
        end else begin
          x_en = 1; x_addr = base + reads;
          pend_v = 1; pend_col = reads; pend_dat = mram[base + reads];
          reads++;
          if (since < MB) since++;
        end
      end
      if (wr_ok && (v0 || v1)) begin
        g = (v0 && v1) ? model_pref : (v0 ? 0 : 1);
        model_pref = 1 - g;
        ga = g ? a1 : a0;
        gd = g ? d1 : d0;
        x_r0 = (g == 0); x_r1 = (g == 1);
        if (ga < FB) begin
          x_en = 1; x_we = 1; x_addr = ga; x_wd = gd;
          mram[ga] = gd;
        end
      end
      if (drain_ph) drained = 1;
      if (post_ph) ended = 1;

      vec_cnt++;
      if ({fetch_busy, fetch_done, overrun, wr0_ready, wr1_ready, mem_en, mem_we} !==
          {x_busy, x_done, 1'b0, x_r0, x_r1, x_en, x_we}) begin
        err_cnt++;
        $display("FAIL fetch_ctrl L%0d c%0d: got busy/done/ov/r0/r1/en/we=%b%b%b%b%b%b%b, want %b%b%b%b%b%b%b",
                 line, c, fetch_busy, fetch_done, overrun, wr0_ready, wr1_ready, mem_en, mem_we,
                 x_busy, x_done, 1'b0, x_r0, x_r1, x_en, x_we);
      end
      if (x_en) begin
        vec_cnt++;
        if (mem_addr !== ADDR_W'(x_addr)) begin
          err_cnt++;
          $display("FAIL fetch_addr L%0d c%0d: got %0d, want %0d", line, c, mem_addr, x_addr);
        end
      end
      if (x_we) begin
        vec_cnt++;
        if (mem_wdata !== x_wd) begin
          err_cnt++;
          $display("FAIL fetch_wdata L%0d c%0d: got %0d, want %0d", line, c, mem_wdata, x_wd);
        end
      end
      vec_cnt++;
      if (lb_we !== x_lb) begin
        err_cnt++;
        $display("FAIL lb_we L%0d c%0d: got %b, want %b", line, c, lb_we, x_lb);
      end else if (x_lb) begin
        vec_cnt++;
        if ({lb_addr, lb_wdata} !== {COL_W'(x_col), x_dat}) begin
          err_cnt++;
          $display("FAIL lb_data L%0d c%0d: got col=%0d d=%0d, want col=%0d d=%0d",
                   line, c, lb_addr, lb_wdata, x_col, x_dat);
        end
      end
      if (fetch_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      c++;
    end
    drive_quiet();
    vec_cnt++;
    if (!ended) begin
      err_cnt++;
      $display("FAIL fetch_timeout L%0d: got %0d cycles, want end within %0d", line, c, 4 * HD + 8);
    end
    vec_cnt++;
    if (done_cnt != 1 || done_at != HD + slots + 1) begin
      err_cnt++;
      $display("FAIL fetch_latency L%0d: got %0d pulses at c%0d, want 1 at c%0d",
               line, done_cnt, done_at, HD + slots + 1);
    end
    if (exp_lat >= 0) begin
      vec_cnt++;
      if (done_at != exp_lat) begin
        err_cnt++;
        $display("FAIL fetch_done_cycle L%0d: got c%0d, want c%0d", line, done_at, exp_lat);
      end
    end
  endtask

  task automatic test_basic_fetch();
    run_fetch(2, 0, HD + 1);
  endtask

  task automatic test_starvation();
    run_fetch(1, 1, 12);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) run_fetch($urandom_range(0, VD - 1), 2, -1);
  endtask

  task automatic test_ignored_line();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      line_start = (c == 0); line_idx = COL_W'(VD);
      #3;
      vec_cnt++;
      if ({fetch_busy, overrun, mem_en, lb_we} !== 4'b0000) begin
        err_cnt++;
        $display("FAIL ignored_line c%0d: got busy/ov/en/lb=%b%b%b%b, want 0000",
                 c, fetch_busy, overrun, mem_en, lb_we);
      end
    end
    drive_quiet();
  endtask

  task automatic test_overrun();
    bit x_rd, x_lb, x_done, x_ov, x_busy;
    int x_addr, x_col, x_base, done_cnt;
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      next_cycle();
      line_start = (c == 0) || (c == 4);
      line_idx = (c == 4) ? COL_W'(3) : COL_W'(0);
      #3;
      x_rd   = (c >= 1 && c <= 3) || (c >= 5 && c <= 12);
      x_addr = (c <= 3) ? c - 1 : 24 + c - 5;
      x_lb   = (c >= 2 && c <= 4) || (c >= 6 && c <= 13);
      x_col  = (c <= 4) ? c - 2 : c - 6;
      x_base = (c <= 4) ? 0 : 24;
      x_done = (c == 13);
      x_ov   = (c == 4);
      x_busy = (c >= 1 && c <= 13);
      vec_cnt++;
      if ({fetch_busy, fetch_done, overrun, mem_en, mem_we, lb_we} !==
          {x_busy, x_done, x_ov, x_rd, 1'b0, x_lb}) begin
        err_cnt++;
        $display("FAIL overrun_ctrl c%0d: got busy/done/ov/en/we/lb=%b%b%b%b%b%b, want %b%b%b%b%b%b",
                 c, fetch_busy, fetch_done, overrun, mem_en, mem_we, lb_we,
                 x_busy, x_done, x_ov, x_rd, 1'b0, x_lb);
      end
      if (x_rd) begin
        vec_cnt++;
        if (mem_addr !== ADDR_W'(x_addr)) begin
          err_cnt++;
          $display("FAIL overrun_addr c%0d: got %0d, want %0d", c, mem_addr, x_addr);
        end
      end
      if (x_lb) begin
        vec_cnt++;
        if ({lb_addr, lb_wdata} !== {COL_W'(x_col), mram[x_base + x_col]}) begin
          err_cnt++;
          $display("FAIL overrun_lb c%0d: got col=%0d d=%0d, want col=%0d d=%0d",
                   c, lb_addr, lb_wdata, x_col, mram[x_base + x_col]);
        end
      end
      if (fetch_done === 1'b1) done_cnt++;
    end
    drive_quiet();
    vec_cnt++;
    if (done_cnt != 1) begin
      err_cnt++;
      $display("FAIL overrun_done_count: got %0d, want 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_fetch();
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      line_start = (c == 0); line_idx = COL_W'(1);
    end
    line_start = 1'b0;
    #3;
    vec_cnt++;
    if ({mem_en, mem_addr} !== {1'b1, ADDR_W'(HD + 5)}) begin
      err_cnt++;
      $display("FAIL pre_reset_col5: got en=%b a=%0d, want en=1 a=%0d", mem_en, mem_addr, HD + 5);
    end
    #1;
    arstn = 1'b0;
    #1;
    vec_cnt++;
    if (all_outs() !== '0) begin
      err_cnt++;
      $display("FAIL reset_mid_fetch: got %h, want 0", all_outs());
    end
    next_cycle();
    next_cycle();
    arstn = 1'b1;
    model_pref = 0;
    for (int c = 0; c < 4; c++) begin
      #3;
      vec_cnt++;
      if ({fetch_busy, fetch_done, lb_we, mem_en} !== 4'b0000) begin
        err_cnt++;
        $display("FAIL post_reset_idle c%0d: got busy/done/lb/en=%b%b%b%b, want 0000",
                 c, fetch_busy, fetch_done, lb_we, mem_en);
      end
      next_cycle();
    end
    wr0_valid = 1'b1; wr0_addr = 6'd3; wr0_data = 2'd1;
    wr1_valid = 1'b1; wr1_addr = 6'd5; wr1_data = 2'd2;
    #3;
    vec_cnt++;
    if ({wr0_ready, wr1_ready, mem_en, mem_addr} !== {1'b1, 1'b0, 1'b1, ADDR_W'(3)}) begin
      err_cnt++;
      $display("FAIL post_reset_rr: got r0=%b r1=%b en=%b a=%0d, want r0=1 r1=0 en=1 a=3",
               wr0_ready, wr1_ready, mem_en, mem_addr);
    end
    mram[3] = 2'd1;
    model_pref = 1;
    next_cycle();
    drive_quiet();
  endtask

  initial begin
    arstn = 1'b0;
    ram_load = 1'b0;
    drive_quiet();
    for (int i = 0; i < RAM_N; i++) mram[i] = PIX_W'($urandom);
    test_reset();
    test_round_robin();
    test_out_of_range();
    test_basic_fetch();
    test_starvation();
    test_ignored_line();
    test_random();
    test_overrun();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
